// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback path: op codes, op classes and sequencer states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_MOVE = 4'b0111;
    localparam logic [3:0] OP_SWAP = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1011;

    localparam logic [3:0] REM_REG_ADDR = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StWrLo,
        StWrHi,
        StHalt
    } wb_state_e;

    typedef enum logic [1:0] {
        ClsArith,
        ClsDual,
        ClsSingle,
        ClsIllegal
    } op_class_e;

endpackage

// File: rtl/alu_op_class.sv
// Combinational decode of an ALU op code into its writeback class.
module alu_op_class
    import alu_pkg::*;
(
    input  logic [3:0] alu_op,
    output op_class_e  op_class
);

    always_comb begin
        op_class = ClsIllegal;
        case (alu_op)
            OP_ADD, OP_SUB, OP_MUL:  op_class = ClsArith;
            OP_DIV, OP_SWAP:         op_class = ClsDual;
            OP_MOVE, OP_AND, OP_OR:  op_class = ClsSingle;
            default:                 op_class = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/alu_writeback_seq.sv
// Captures ALU results and sequences one or two register-file writes per op;
// arithmetic overflow halts the stage with a sticky exception until reset.
module alu_writeback_seq
    import alu_pkg::*;
#(
    parameter int unsigned    DW      = 16,
    parameter int unsigned    AW      = 4,
    parameter logic [AW-1:0]  REM_REG = AW'(alu_pkg::REM_REG_ADDR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    alu_op,
    input  logic [DW-1:0] lower,
    input  logic [DW-1:0] upper,
    input  logic          overflow,
    input  logic [AW-1:0] dest1,
    input  logic [AW-1:0] dest2,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          exc,
    output logic [3:0]    exc_op,
    output logic          illegal
);

    wb_state_e     r_state, w_state_d, w_accept_state;
    op_class_e     w_in_class, r_class;
    logic [3:0]    r_op;
    logic [DW-1:0] r_lower, r_upper;
    logic [AW-1:0] r_dest1, r_dest2;
    logic          r_exc, r_illegal;
    logic [3:0]    r_exc_op;
    logic          w_accept, w_ovf_hit;

    alu_op_class u_op_class (
        .alu_op   (alu_op),
        .op_class (w_in_class)
    );

    assign w_accept  = in_valid & in_ready;
    assign w_ovf_hit = w_accept & (w_in_class == ClsArith) & overflow;

    always_comb begin
        w_accept_state = StWrLo;
        if (w_in_class == ClsArith && overflow) begin
            w_accept_state = StHalt;
        end else if (w_in_class == ClsIllegal) begin
            w_accept_state = StIdle;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StWrHi: w_state_d = w_accept ? w_accept_state : StIdle;
            // A dual op always moves on to its second write; in_ready is low here.
            StWrLo: begin
                if (r_class == ClsDual) begin
                    w_state_d = StWrHi;
                end else begin
                    w_state_d = w_accept ? w_accept_state : StIdle;
                end
            end
            StHalt: w_state_d = StHalt;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        unique case (r_state)
            StIdle: in_ready = 1'b1;
            StWrLo: begin
                in_ready = (r_class != ClsDual);
                rf_we    = 1'b1;
                rf_waddr = r_dest1;
                rf_wdata = r_lower;
            end
            StWrHi: begin
                in_ready = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = (r_op == OP_DIV) ? REM_REG : r_dest2;
                rf_wdata = r_upper;
            end
            StHalt: in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_class   <= ClsIllegal;
            r_op      <= '0;
            r_lower   <= '0;
            r_upper   <= '0;
            r_dest1   <= '0;
            r_dest2   <= '0;
            r_exc     <= 1'b0;
            r_exc_op  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_illegal <= w_accept & (w_in_class == ClsIllegal);
            if (w_ovf_hit) begin
                r_exc    <= 1'b1;
                r_exc_op <= alu_op;
            end
            if (w_accept) begin
                r_class <= w_in_class;
                r_op    <= alu_op;
                r_lower <= lower;
                r_upper <= upper;
                r_dest1 <= dest1;
                r_dest2 <= dest2;
            end
        end
    end

    assign exc     = r_exc;
    assign exc_op  = r_exc_op;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Directed self-checking bench for alu_writeback_seq.
module tb_alu_writeback_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [15:0] lower;
    logic [15:0] upper;
    logic        overflow;
    logic [3:0]  dest1;
    logic [3:0]  dest2;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        exc;
    logic [3:0]  exc_op;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_writeback_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_op   (alu_op),
        .lower    (lower),
        .upper    (upper),
        .overflow (overflow),
        .dest1    (dest1),
        .dest2    (dest2),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .exc      (exc),
        .exc_op   (exc_op),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] lo, input logic [15:0] hi,
                         input logic ovf, input logic [3:0] d1, input logic [3:0] d2);
        in_valid = 1'b1;
        alu_op   = op;
        lower    = lo;
        upper    = hi;
        overflow = ovf;
        dest1    = d1;
        dest2    = d2;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        overflow = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [3:0] a,
                          input logic [15:0] d, input logic rdy);
        chk({tag, ".we"}, 32'(rf_we), 32'(we));
        chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
        chk({tag, ".data"}, 32'(rf_wdata), 32'(d));
        chk({tag, ".ready"}, 32'(in_ready), 32'(rdy));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; alu_op = '0; lower = '0; upper = '0;
        overflow = 1'b0; dest1 = '0; dest2 = '0;
        tick();
        tick();
        chk_wr("reset", 1'b0, 4'h0, 16'h0000, 1'b1);
        chk("reset.exc", 32'(exc), 0);
        chk("reset.exc_op", 32'(exc_op), 0);
        chk("reset.illegal", 32'(illegal), 0);
        rst = 1'b0;
        tick();

        // MOVE: single write
        drive(4'b0111, 16'h1234, 16'h0000, 1'b0, 4'd3, 4'd0);
        tick();
        idle_in();
        chk_wr("move", 1'b1, 4'd3, 16'h1234, 1'b1);
        tick();
        chk_wr("move.after", 1'b0, 4'd0, 16'h0000, 1'b1);

        // DIV: quotient then remainder to R15
        drive(4'b0101, 16'h0007, 16'h0002, 1'b0, 4'd5, 4'd0);
        tick();
        idle_in();
        chk_wr("div.lo", 1'b1, 4'd5, 16'h0007, 1'b0);
        tick();
        chk_wr("div.hi", 1'b1, 4'hF, 16'h0002, 1'b1);
        tick();
        chk_wr("div.after", 1'b0, 4'd0, 16'h0000, 1'b1);

        // SWAP: dest1 then dest2
        drive(4'b1000, 16'hAAAA, 16'h5555, 1'b0, 4'd1, 4'd2);
        tick();
        idle_in();
        chk_wr("swap.lo", 1'b1, 4'd1, 16'hAAAA, 1'b0);
        tick();
        chk_wr("swap.hi", 1'b1, 4'd2, 16'h5555, 1'b1);
        tick();
        chk("swap.after.we", 32'(rf_we), 0);

        // Illegal op 0011
        drive(4'b0011, 16'hDEAD, 16'hBEEF, 1'b0, 4'd9, 4'd0);
        tick();
        idle_in();
        chk("illegal.pulse", 32'(illegal), 1);
        chk("illegal.we", 32'(rf_we), 0);
        tick();
        chk("illegal.clear", 32'(illegal), 0);
        chk("illegal.we2", 32'(rf_we), 0);

        // Back-to-back AND, OR, DIV, MOVE
        drive(4'b1001, 16'h00F0, 16'h0000, 1'b0, 4'd4, 4'd0);
        tick();
        chk_wr("strm.and", 1'b1, 4'd4, 16'h00F0, 1'b1);
        drive(4'b1011, 16'h0F00, 16'h0000, 1'b0, 4'd6, 4'd0);
        tick();
        chk_wr("strm.or", 1'b1, 4'd6, 16'h0F00, 1'b1);
        drive(4'b0101, 16'h0009, 16'h0001, 1'b0, 4'd7, 4'd0);
        tick();
        drive(4'b0111, 16'hBEEF, 16'h0000, 1'b0, 4'd8, 4'd0);
        chk_wr("strm.div.lo", 1'b1, 4'd7, 16'h0009, 1'b0);
        tick();
        chk_wr("strm.div.hi", 1'b1, 4'hF, 16'h0001, 1'b1);
        tick();
        idle_in();
        chk_wr("strm.move", 1'b1, 4'd8, 16'hBEEF, 1'b1);
        tick();
        chk("strm.after.we", 32'(rf_we), 0);

        // Reset during WR_LO of DIV drops the remainder write
        drive(4'b0101, 16'h0003, 16'h0004, 1'b0, 4'd5, 4'd0);
        tick();
        idle_in();
        chk_wr("rstmid.lo", 1'b1, 4'd5, 16'h0003, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_wr("rstmid.reset", 1'b0, 4'd0, 16'h0000, 1'b1);
        chk("rstmid.exc", 32'(exc), 0);
        tick();
        chk("rstmid.no_hi", 32'(rf_we), 0);

        // DIV to R15: remainder written last
        drive(4'b0101, 16'h0011, 16'h0022, 1'b0, 4'hF, 4'd0);
        tick();
        idle_in();
        chk_wr("divf.lo", 1'b1, 4'hF, 16'h0011, 1'b0);
        tick();
        chk_wr("divf.hi", 1'b1, 4'hF, 16'h0022, 1'b1);

        // Overflow on a non-arith op is ignored
        drive(4'b0111, 16'h4242, 16'h0000, 1'b1, 4'd10, 4'd0);
        tick();
        idle_in();
        chk_wr("movovf", 1'b1, 4'd10, 16'h4242, 1'b1);
        chk("movovf.exc", 32'(exc), 0);
        tick();

        // Reset and valid on the same edge: input discarded
        rst = 1'b1;
        drive(4'b0111, 16'h7777, 16'h0000, 1'b0, 4'd11, 4'd0);
        tick();
        rst = 1'b0;
        idle_in();
        chk("rstvalid.we", 32'(rf_we), 0);
        tick();
        chk("rstvalid.we2", 32'(rf_we), 0);

        // ADD without overflow writes normally
        drive(4'b0000, 16'h0100, 16'h0000, 1'b0, 4'd12, 4'd0);
        tick();
        idle_in();
        chk_wr("add", 1'b1, 4'd12, 16'h0100, 1'b1);
        tick();

        // ADD overflow halts until reset
        drive(4'b0000, 16'hFFFF, 16'h0000, 1'b1, 4'd2, 4'd0);
        tick();
        drive(4'b0111, 16'h1111, 16'h0000, 1'b0, 4'd3, 4'd0);
        chk_wr("ovf", 1'b0, 4'd0, 16'h0000, 1'b0);
        chk("ovf.exc", 32'(exc), 1);
        chk("ovf.exc_op", 32'(exc_op), 32'h0);
        tick();
        chk_wr("halt1", 1'b0, 4'd0, 16'h0000, 1'b0);
        tick();
        idle_in();
        chk_wr("halt2", 1'b0, 4'd0, 16'h0000, 1'b0);
        chk("halt2.exc", 32'(exc), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt.rst.exc", 32'(exc), 0);
        chk("halt.rst.ready", 32'(in_ready), 1);
        tick();

        // MUL overflow records its op code
        drive(4'b0100, 16'h8000, 16'h0001, 1'b1, 4'd6, 4'd0);
        tick();
        idle_in();
        chk("mulovf.exc", 32'(exc), 1);
        chk("mulovf.exc_op", 32'(exc_op), 32'h4);
        chk("mulovf.we", 32'(rf_we), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mulovf.rst.exc_op", 32'(exc_op), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback_seq.md
# alu_writeback_seq

Writeback sequencer sitting directly downstream of the 16-bit ALU. Captures each ALU result (Lower, Upper, Overflow) with its op code and destination register numbers, then drives the single-write-port register file: one write for most ops, two consecutive writes for DIV (quotient, then remainder to R15) and SWAP. An arithmetic overflow suppresses the write, raises a sticky exception and halts the stage until reset.

## Interface
Parameters:
- DW, 16, data width (matches ALU Upper/Lower)
- AW, 4, register-file address width
- REM_REG, 4'hF, destination of DIV remainder

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ALU result + tags valid this cycle
- in_ready  out  1  stage can accept this cycle
- alu_op  in  4  op code presented to the ALU
- lower  in  DW  ALU Lower
- upper  in  DW  ALU Upper
- overflow  in  1  ALU Overflow
- dest1  in  AW  primary destination (op1 register)
- dest2  in  AW  secondary destination (SWAP only)
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  write address
- rf_wdata  out  DW  write data
- exc  out  1  sticky overflow exception
- exc_op  out  4  op code that caused exc
- illegal  out  1  one-cycle pulse: unsupported op dropped

## Operation
- Op classes: ARITH = 0000 ADD, 0001 SUB, 0100 MUL; DUAL = 0101 DIV, 1000 SWAP; SINGLE = 0111 MOVE, 1001 AND, 1011 OR; all other codes ILLEGAL.
- Accept = in_valid & in_ready; all inputs captured into holding registers on the accept edge.
- States: IDLE, WR_LO, WR_HI, HALT.
- IDLE/WR_LO/WR_HI on accept: ARITH with overflow=1 -> HALT, exc<=1, exc_op<=alu_op, no write; ARITH without overflow, SINGLE, DUAL -> WR_LO; ILLEGAL -> illegal pulses next cycle, no write, state -> IDLE.
- No accept: WR_LO (non-DUAL) -> IDLE; WR_LO (DUAL) -> WR_HI unconditionally; WR_HI -> IDLE.
- WR_LO: rf_we=1, rf_waddr=dest1, rf_wdata=lower.
- WR_HI: rf_we=1, rf_wdata=upper, rf_waddr=REM_REG for DIV, dest2 for SWAP.
- in_ready = 1 in IDLE, WR_HI, and WR_LO of a non-DUAL op; 0 in WR_LO of a DUAL op and in HALT.
- HALT: rf_we=0, in_ready=0, exc=1 held; exit only via rst.
- Overflow ignored for non-ARITH ops.
- DIV with remainder destined to dest1=REM_REG: both writes issued in order; remainder wins.

## Timing
- Reset values: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, exc 0, exc_op 0, illegal 0, in_ready 1 (cycle after reset edge).
- rf_* outputs come only from holding registers/state; no combinational path from inputs.
- Latency: accept at edge N -> write in cycle N..N+1 (rf_we high after edge N); DUAL second write after edge N+1.
- Throughput: one SINGLE/ARITH op per cycle back-to-back; DUAL occupies 2 cycles (one bubble on in_ready).
- Accept in WR_HI: new op's WR_LO follows immediately after the WR_HI cycle.
- rst mid-operation: pending WR_HI dropped; rf_we 0 in the cycle after the reset edge; exc cleared.
- rst and in_valid same edge: rst wins, input discarded.

## Structure
- Shared package alu_pkg: op-code constants (OP_ADD..OP_OR), REM_REG constant, state enum, op-class enum.
- One sub-module natural: alu_op_class (combinational alu_op -> class decode), reusable by the ALU control block.

## Test plan
- MOVE lower=0x1234 dest1=3 -> one cycle rf_we=1, waddr=3, wdata=0x1234; in_ready stays 1.
- DIV lower=0x0007 upper=0x0002 dest1=5 -> write R5=0x0007 then R15=0x0002 on consecutive cycles; in_ready 0 during first write.
- SWAP lower=0xAAAA upper=0x5555 dest1=1 dest2=2 -> R1=0xAAAA then R2=0x5555.
- ADD overflow=1 then further valid ops -> no write, exc=1, exc_op=0000, in_ready 0 until rst; rst clears exc.
- alu_op=0011 -> illegal pulses one cycle, no write; back-to-back AND,OR,DIV,MOVE stream -> writes in order, exactly one bubble.
- rst asserted in WR_LO of DIV -> no WR_HI write, all outputs at reset values next cycle.
